// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: owns the game state, scores, serve delay and winner.
// Button and ball-flag inputs act only on their rising edges.
module pong_game_ctrl #(
    parameter int unsigned WIN_SCORE = 5,
    parameter int unsigned SERVE_MS  = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1ms,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       p1_win,
    input  logic       p2_win,
    output logic [2:0] state,
    output logic       ball_move_en,
    output logic       game_end,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [1:0] winner
);

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        P1_POINT  = 3'b001,
        P2_POINT  = 3'b010,
        PLAY      = 3'b011,
        GAME_OVER = 3'b100,
        PAUSE     = 3'b111
    } state_t;

    localparam logic [3:0]  WIN_PTS   = 4'(WIN_SCORE);
    localparam logic [15:0] SERVE_CNT = 16'(SERVE_MS);

    state_t      state_q, state_n;
    logic [3:0]  p1_q, p1_n, p2_q, p2_n;
    logic [1:0]  win_q, win_n;
    logic [15:0] cnt_q, cnt_n, cnt_inc;
    logic        bme_q, ge_q;

    logic start_d, pause_d, p1_d, p2_d;
    logic start_rise, pause_rise, p1_rise, p2_rise;

    assign start_rise = start_btn & ~start_d;
    assign pause_rise = pause_btn & ~pause_d;
    assign p1_rise    = p1_win    & ~p1_d;
    assign p2_rise    = p2_win    & ~p2_d;
    assign cnt_inc    = cnt_q + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_d <= 1'b0;
            pause_d <= 1'b0;
            p1_d    <= 1'b0;
            p2_d    <= 1'b0;
        end else begin
            start_d <= start_btn;
            pause_d <= pause_btn;
            p1_d    <= p1_win;
            p2_d    <= p2_win;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            p1_q    <= '0;
            p2_q    <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            bme_q   <= 1'b0;
            ge_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            p1_q    <= p1_n;
            p2_q    <= p2_n;
            win_q   <= win_n;
            cnt_q   <= cnt_n;
            bme_q   <= (state_n == PLAY);
            ge_q    <= (state_n == GAME_OVER);
        end
    end

    always_comb begin
        state_n = state_q;
        p1_n    = p1_q;
        p2_n    = p2_q;
        win_n   = win_q;
        cnt_n   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    p1_n    = '0;
                    p2_n    = '0;
                    win_n   = '0;
                    state_n = PLAY;
                end
            end
            PLAY: begin
                // Player 1 beats player 2, and any win beats pause.
                if (p1_rise) begin
                    p1_n    = (p1_q == 4'hF) ? p1_q : p1_q + 4'd1;
                    cnt_n   = '0;
                    state_n = P1_POINT;
                end else if (p2_rise) begin
                    p2_n    = (p2_q == 4'hF) ? p2_q : p2_q + 4'd1;
                    cnt_n   = '0;
                    state_n = P2_POINT;
                end else if (pause_rise) begin
                    state_n = PAUSE;
                end
            end
            PAUSE: begin
                if (pause_rise) state_n = PLAY;
            end
            P1_POINT, P2_POINT: begin
                if (tick_1ms) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == SERVE_CNT) begin
                        if (p1_q == WIN_PTS || p2_q == WIN_PTS) begin
                            win_n   = (p1_q > p2_q) ? 2'b01 : 2'b10;
                            state_n = GAME_OVER;
                        end else begin
                            state_n = PLAY;
                        end
                    end
                end
            end
            GAME_OVER: begin
                if (start_rise) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign state        = state_q;
    assign ball_move_en = bme_q;
    assign game_end     = ge_q;
    assign p1_score     = p1_q;
    assign p2_score     = p2_q;
    assign winner       = win_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed test-plan walk plus randomized play against a rule-level game model.
module tb_pong_game_ctrl;

    localparam int WIN = 2;
    localparam int SRV = 3;

    localparam int S_IDLE = 0, S_P1 = 1, S_P2 = 2, S_PLAY = 3, S_OVER = 4, S_PAUSE = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1ms = 1'b0, start_btn = 1'b0, pause_btn = 1'b0, p1_win = 1'b0, p2_win = 1'b0;
    logic [2:0] state;
    logic       ball_move_en, game_end;
    logic [3:0] p1_score, p2_score;
    logic [1:0] winner;

    int tests = 0;
    int fails = 0;

    // reference model
    int m_state, m_p1, m_p2, m_win, m_ticks;
    bit pv_start, pv_pause, pv_p1, pv_p2;

    pong_game_ctrl #(.WIN_SCORE(WIN), .SERVE_MS(SRV)) dut (
        .clk(clk), .reset(reset), .tick_1ms(tick_1ms), .start_btn(start_btn),
        .pause_btn(pause_btn), .p1_win(p1_win), .p2_win(p2_win), .state(state),
        .ball_move_en(ball_move_en), .game_end(game_end), .p1_score(p1_score),
        .p2_score(p2_score), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_p1 = 0; m_p2 = 0; m_win = 0; m_ticks = 0;
        pv_start = 0; pv_pause = 0; pv_p1 = 0; pv_p2 = 0;
    endtask

    // One clock of game rules, applied to the inputs present at the edge.
    task automatic model_step();
        bit rs, rp, r1, r2;
        rs = start_btn && !pv_start;
        rp = pause_btn && !pv_pause;
        r1 = p1_win && !pv_p1;
        r2 = p2_win && !pv_p2;
        if (m_state == S_IDLE) begin
            if (rs) begin m_p1 = 0; m_p2 = 0; m_win = 0; m_state = S_PLAY; end
        end else if (m_state == S_PLAY) begin
            if (r1) begin
                if (m_p1 < 15) m_p1++;
                m_ticks = 0; m_state = S_P1;
            end else if (r2) begin
                if (m_p2 < 15) m_p2++;
                m_ticks = 0; m_state = S_P2;
            end else if (rp) m_state = S_PAUSE;
        end else if (m_state == S_PAUSE) begin
            if (rp) m_state = S_PLAY;
        end else if (m_state == S_P1 || m_state == S_P2) begin
            if (tick_1ms) begin
                m_ticks++;
                if (m_ticks == SRV) begin
                    if (m_p1 == WIN || m_p2 == WIN) begin
                        m_win = (m_p1 > m_p2) ? 1 : 2;
                        m_state = S_OVER;
                    end else m_state = S_PLAY;
                end
            end
        end else if (m_state == S_OVER) begin
            if (rs) m_state = S_IDLE;
        end
        pv_start = start_btn; pv_pause = pause_btn; pv_p1 = p1_win; pv_p2 = p2_win;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, int'(state), m_state);
        chk({tag, ".ball_move_en"}, int'(ball_move_en), int'(m_state == S_PLAY));
        chk({tag, ".game_end"}, int'(game_end), int'(m_state == S_OVER));
        chk({tag, ".p1_score"}, int'(p1_score), m_p1);
        chk({tag, ".p2_score"}, int'(p2_score), m_p2);
        chk({tag, ".winner"}, int'(winner), m_win);
    endtask

    // Apply inputs at the falling edge, clock once, compare just after the rising edge.
    task automatic cyc(input bit s, input bit p, input bit a, input bit b, input bit t, input string tag);
        @(negedge clk);
        start_btn = s; pause_btn = p; p1_win = a; p2_win = b; tick_1ms = t;
        @(posedge clk);
        if (reset) model_reset(); else model_step();
        #1;
        check_all(tag);
    endtask

    // Three ticks spread over six cycles, with ball flags held at the given levels.
    task automatic serve(input bit a, input bit b, input string tag);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, a, b, 1, tag);
            cyc(0, 0, a, b, 0, tag);
        end
    endtask

    initial begin
        model_reset();
        cyc(0, 0, 0, 0, 0, "rst");
        cyc(1, 0, 0, 0, 0, "rst_start_ignored");
        chk("rst.state_const", int'(state), S_IDLE);
        reset = 1'b0;
        cyc(0, 0, 0, 0, 0, "idle");
        cyc(0, 0, 0, 0, 1, "idle");
        chk("idle.state_const", int'(state), S_IDLE);

        cyc(1, 0, 0, 0, 0, "start");
        chk("start.state_const", int'(state), S_PLAY);
        chk("start.bme_const", int'(ball_move_en), 1);
        for (int i = 0; i < 100; i++) cyc(1, 0, 0, 0, i % 2, "start_hold");
        chk("start_hold.state_const", int'(state), S_PLAY);

        cyc(0, 0, 1, 0, 1, "p1_point");
        chk("p1_point.state_const", int'(state), S_P1);
        chk("p1_point.score_const", int'(p1_score), 1);
        chk("p1_point.bme_const", int'(ball_move_en), 0);
        cyc(0, 0, 1, 0, 1, "serve1");
        cyc(0, 0, 1, 0, 1, "serve1");
        chk("serve1.two_ticks", int'(state), S_P1);
        cyc(0, 0, 1, 0, 1, "serve1");
        chk("serve1.three_ticks", int'(state), S_PLAY);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0, "p1_held");
        chk("p1_held.score_const", int'(p1_score), 1);

        cyc(0, 0, 0, 0, 0, "p1_release");
        cyc(0, 0, 1, 0, 0, "p1_point2");
        chk("p1_point2.score_const", int'(p1_score), 2);
        serve(0, 0, "serve2");
        chk("over.state_const", int'(state), S_OVER);
        chk("over.game_end_const", int'(game_end), 1);
        chk("over.winner_const", int'(winner), 1);

        cyc(1, 0, 0, 0, 0, "to_idle");
        chk("to_idle.state_const", int'(state), S_IDLE);
        chk("to_idle.p1_kept", int'(p1_score), 2);
        cyc(0, 0, 0, 0, 0, "to_idle");
        cyc(1, 0, 0, 0, 0, "restart");
        chk("restart.p1_cleared", int'(p1_score), 0);
        chk("restart.winner_cleared", int'(winner), 0);
        chk("restart.state_const", int'(state), S_PLAY);
        cyc(0, 0, 0, 0, 0, "restart");

        cyc(0, 1, 0, 0, 0, "pause");
        chk("pause.state_const", int'(state), S_PAUSE);
        cyc(0, 0, 0, 0, 0, "pause");
        cyc(0, 0, 0, 1, 0, "pause_p2");
        chk("pause_p2.score_const", int'(p2_score), 0);
        cyc(0, 0, 0, 0, 0, "pause");
        cyc(0, 1, 0, 0, 0, "unpause");
        chk("unpause.state_const", int'(state), S_PLAY);
        cyc(0, 0, 0, 0, 0, "unpause");

        cyc(0, 0, 1, 1, 0, "race_p1p2");
        chk("race_p1p2.state_const", int'(state), S_P1);
        chk("race_p1p2.p2_const", int'(p2_score), 0);
        serve(0, 0, "race_serve");
        cyc(0, 1, 0, 1, 0, "race_pause_p2");
        chk("race_pause_p2.state_const", int'(state), S_P2);
        chk("race_pause_p2.p2_const", int'(p2_score), 1);
        cyc(0, 0, 0, 0, 1, "mid");

        // asynchronous reset in the middle of a clock period
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("async_rst.state", int'(state), S_IDLE);
        chk("async_rst.p2", int'(p2_score), 0);
        chk("async_rst.p1", int'(p1_score), 0);
        cyc(0, 0, 0, 0, 0, "async_rst_hold");
        reset = 1'b0;
        cyc(0, 0, 0, 0, 0, "after_rst");

        for (int i = 0; i < 4000; i++) begin
            bit s, p, a, b, t;
            s = start_btn; p = pause_btn; a = p1_win; b = p2_win;
            if ($urandom_range(0, 7) == 0) s = ~s;
            if ($urandom_range(0, 11) == 0) p = ~p;
            if ($urandom_range(0, 9) == 0) a = ~a;
            if ($urandom_range(0, 9) == 0) b = ~b;
            t = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 599) == 0);
            cyc(s, p, a, b, t, "rand");
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
